// File: rtl/imem_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : imem_fetch_ctrl
// Brief    : Instruction-fetch sequencer: owns the PC, arbitrates IMEM between
//            the boot loader and fetch, and registers instruction/PC to decode.
// Revision : 1.0 - initial release
// ============================================================================
module imem_fetch_ctrl #(
    parameter logic [31:0] START_ADDR = 32'h0040_0000,
    parameter int          DEPTH      = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_en,
    input  logic        load_valid,
    input  logic [31:0] load_data,
    output logic        load_ready,
    input  logic        start,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    output logic [31:0] imem_pc,
    output logic        imem_we,
    output logic [31:0] imem_wdata,
    input  logic [31:0] imem_instruction,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_instruction,
    output logic        fault,
    output logic [31:0] fault_pc,
    output logic [2:0]  state
);

    localparam int                CNT_W       = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0]  c_DEPTH     = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]  c_LAST_CNT  = CNT_W'(DEPTH - 1);
    localparam logic [31:0]       c_LAST_ADDR = START_ADDR + 32'(4 * (DEPTH - 1));

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_RUN   = 3'd2,
        S_HALT  = 3'd3,
        S_FAULT = 3'd4
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [31:0]      r_pc, w_pc_nxt;
    logic [CNT_W-1:0] r_load_cnt, w_load_cnt_nxt;
    logic             r_if_valid, w_if_valid_nxt;
    logic [31:0]      r_if_pc, w_if_pc_nxt;
    logic [31:0]      r_if_instr, w_if_instr_nxt;
    logic             r_fault, w_fault_nxt;
    logic [31:0]      r_fault_pc, w_fault_pc_nxt;

    logic             w_load_ready;
    logic             w_accept;
    logic [31:0]      w_load_addr;
    logic             w_redir_ok;
    logic             w_pc_ok;

    assign w_load_ready = (r_state == S_LOAD) && (r_load_cnt < c_DEPTH);
    assign w_accept     = load_valid && w_load_ready;
    assign w_load_addr  = START_ADDR + {{(30 - CNT_W){1'b0}}, r_load_cnt, 2'b00};

    // Full 32-bit unsigned bounds: no wrap-around past the last IMEM word.
    assign w_redir_ok = (redirect_pc[1:0] == 2'b00) && (redirect_pc >= START_ADDR)
                        && (redirect_pc <= c_LAST_ADDR);
    assign w_pc_ok    = (r_pc >= START_ADDR) && (r_pc <= c_LAST_ADDR);

    always_comb begin
        w_state_nxt     = r_state;
        w_pc_nxt        = r_pc;
        w_load_cnt_nxt  = r_load_cnt;
        w_if_valid_nxt  = r_if_valid;
        w_if_pc_nxt     = r_if_pc;
        w_if_instr_nxt  = r_if_instr;
        w_fault_nxt     = r_fault;
        w_fault_pc_nxt  = r_fault_pc;

        case (r_state)
            S_IDLE: begin
                if (load_en) begin
                    w_state_nxt    = S_LOAD;
                    w_load_cnt_nxt = '0;
                end else if (start) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_LOAD: begin
                if (w_accept) begin
                    w_load_cnt_nxt = r_load_cnt + 1'b1;
                end
                if (!load_en || (w_accept && (r_load_cnt == c_LAST_CNT))) begin
                    w_state_nxt = S_IDLE;
                    w_pc_nxt    = START_ADDR;
                end
            end
            S_RUN: begin
                if (halt) begin
                    w_state_nxt    = S_HALT;
                    w_if_valid_nxt = 1'b0;
                end else if (redirect_valid) begin
                    w_if_valid_nxt = 1'b0;
                    if (w_redir_ok) begin
                        w_pc_nxt = redirect_pc;
                    end else begin
                        w_state_nxt    = S_FAULT;
                        w_fault_nxt    = 1'b1;
                        w_fault_pc_nxt = redirect_pc;
                    end
                end else if (!stall) begin
                    // A sequential step past the last word faults on the next fetch.
                    if (w_pc_ok) begin
                        w_if_instr_nxt = imem_instruction;
                        w_if_pc_nxt    = r_pc;
                        w_if_valid_nxt = 1'b1;
                        w_pc_nxt       = r_pc + 32'd4;
                    end else begin
                        w_state_nxt    = S_FAULT;
                        w_if_valid_nxt = 1'b0;
                        w_fault_nxt    = 1'b1;
                        w_fault_pc_nxt = r_pc;
                    end
                end
            end
            S_HALT: begin
                w_if_valid_nxt = 1'b0;
                if (start) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_FAULT: begin
                w_if_valid_nxt = 1'b0;
                w_fault_nxt    = 1'b1;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc       <= START_ADDR;
            r_load_cnt <= '0;
            r_if_valid <= 1'b0;
            r_if_pc    <= '0;
            r_if_instr <= '0;
            r_fault    <= 1'b0;
            r_fault_pc <= '0;
        end else begin
            r_pc       <= w_pc_nxt;
            r_load_cnt <= w_load_cnt_nxt;
            r_if_valid <= w_if_valid_nxt;
            r_if_pc    <= w_if_pc_nxt;
            r_if_instr <= w_if_instr_nxt;
            r_fault    <= w_fault_nxt;
            r_fault_pc <= w_fault_pc_nxt;
        end
    end

    assign load_ready     = w_load_ready;
    assign imem_pc        = (r_state == S_LOAD) ? w_load_addr : r_pc;
    assign imem_we        = w_accept;
    assign imem_wdata     = (r_state == S_LOAD) ? load_data : 32'd0;
    assign if_valid       = r_if_valid;
    assign if_pc          = r_if_pc;
    assign if_instruction = r_if_instr;
    assign fault          = r_fault;
    assign fault_pc       = r_fault_pc;
    assign state          = r_state;

endmodule
`default_nettype wire

// File: tb/tb_imem_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_imem_fetch_ctrl
// Brief    : Directed vector table plus hand-written corner sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_imem_fetch_ctrl;

    localparam logic [31:0] c_START = 32'h0040_0000;
    localparam logic [31:0] c_W0 = 32'h2008_0005;
    localparam logic [31:0] c_W1 = 32'h2009_0003;
    localparam logic [31:0] c_W2 = 32'h0109_5020;

    logic        clk = 1'b0;
    logic        rst, load_en, load_valid, start, stall, redirect_valid, halt;
    logic [31:0] load_data, redirect_pc;
    logic        load_ready, imem_we, if_valid, fault;
    logic [31:0] imem_pc, imem_wdata, imem_instruction, if_pc, if_instruction, fault_pc;
    logic [2:0]  state;

    int total = 0;
    int bad   = 0;

    logic [31:0] mem [64];
    logic [31:0] w_off;

    always #5 clk = ~clk;

    imem_fetch_ctrl #(.START_ADDR(c_START), .DEPTH(64)) dut (
        .clk(clk), .rst(rst), .load_en(load_en), .load_valid(load_valid),
        .load_data(load_data), .load_ready(load_ready), .start(start), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt(halt),
        .imem_pc(imem_pc), .imem_we(imem_we), .imem_wdata(imem_wdata),
        .imem_instruction(imem_instruction), .if_valid(if_valid), .if_pc(if_pc),
        .if_instruction(if_instruction), .fault(fault), .fault_pc(fault_pc), .state(state)
    );

    // Behavioural IMEM: combinational read, write on clock edge.
    assign w_off = imem_pc - c_START;
    assign imem_instruction = (w_off < 32'd256) ? mem[w_off[7:2]] : 32'hDEAD_BEEF;
    always @(posedge clk) if (imem_we && w_off < 32'd256) mem[w_off[7:2]] <= imem_wdata;

    typedef struct {
        logic        le, lv;
        logic [31:0] ld;
        logic        st, sl, rv;
        logic [31:0] rpc;
        logic        ht;
        logic [31:0] e_ipc;
        logic        e_we, e_lr;
        logic [2:0]  e_st;
        logic        e_ifv;
        logic [31:0] e_ifpc, e_ins;
        logic        e_flt;
    } vec_t;

    vec_t vt [24];

    function automatic vec_t mk(logic le, logic lv, logic [31:0] ld, logic st, logic sl,
                                logic rv, logic [31:0] rpc, logic ht, logic [31:0] e_ipc,
                                logic e_we, logic e_lr, logic [2:0] e_st, logic e_ifv,
                                logic [31:0] e_ifpc, logic [31:0] e_ins, logic e_flt);
        vec_t v;
        v.le = le; v.lv = lv; v.ld = ld; v.st = st; v.sl = sl; v.rv = rv; v.rpc = rpc;
        v.ht = ht; v.e_ipc = e_ipc; v.e_we = e_we; v.e_lr = e_lr; v.e_st = e_st;
        v.e_ifv = e_ifv; v.e_ifpc = e_ifpc; v.e_ins = e_ins; v.e_flt = e_flt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        load_en = 0; load_valid = 0; load_data = 0; start = 0; stall = 0;
        redirect_valid = 0; redirect_pc = 0; halt = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1;
        step();
        step();
        rst = 0;
    endtask

    task automatic redirect_fault(input logic [31:0] tgt);
        do_reset();
        start = 1; step(); start = 0;
        redirect_valid = 1; redirect_pc = tgt; step(); redirect_valid = 0;
        chk("redir_fault_state", 32'(state), 32'd4);
        chk("redir_fault_flag", 32'(fault), 32'd1);
        chk("redir_fault_pc", fault_pc, tgt);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'hA000_0000 + 32'(i);

        //        le lv ld    st sl rv rpc      ht  ipc              we lr st ifv ifpc            ins   flt
        vt[0]  = mk(1, 0, 0,    0, 0, 0, 0,       0, c_START,         0, 0, 1, 0, 0,              0,    0);
        vt[1]  = mk(1, 0, 0,    0, 0, 0, 0,       0, c_START,         0, 1, 1, 0, 0,              0,    0);
        vt[2]  = mk(1, 1, c_W0, 0, 0, 0, 0,       0, c_START,         1, 1, 1, 0, 0,              0,    0);
        vt[3]  = mk(1, 0, 0,    0, 0, 0, 0,       0, c_START + 4,     0, 1, 1, 0, 0,              0,    0);
        vt[4]  = mk(1, 1, c_W1, 0, 0, 0, 0,       0, c_START + 4,     1, 1, 1, 0, 0,              0,    0);
        vt[5]  = mk(1, 1, c_W2, 0, 0, 0, 0,       0, c_START + 8,     1, 1, 1, 0, 0,              0,    0);
        vt[6]  = mk(1, 0, 0,    0, 0, 0, 0,       0, c_START + 12,    0, 1, 1, 0, 0,              0,    0);
        vt[7]  = mk(0, 0, 0,    0, 0, 0, 0,       0, c_START + 12,    0, 1, 0, 0, 0,              0,    0);
        vt[8]  = mk(0, 0, 0,    0, 0, 0, 0,       0, c_START,         0, 0, 0, 0, 0,              0,    0);
        vt[9]  = mk(0, 0, 0,    1, 0, 0, 0,       0, c_START,         0, 0, 2, 0, 0,              0,    0);
        vt[10] = mk(0, 0, 0,    0, 0, 0, 0,       0, c_START,         0, 0, 2, 1, c_START,        c_W0, 0);
        vt[11] = mk(0, 0, 0,    0, 0, 0, 0,       0, c_START + 4,     0, 0, 2, 1, c_START + 4,    c_W1, 0);
        vt[12] = mk(0, 0, 0,    0, 1, 0, 0,       0, c_START + 8,     0, 0, 2, 1, c_START + 4,    c_W1, 0);
        vt[13] = mk(0, 0, 0,    0, 1, 0, 0,       0, c_START + 8,     0, 0, 2, 1, c_START + 4,    c_W1, 0);
        vt[14] = mk(0, 0, 0,    0, 1, 0, 0,       0, c_START + 8,     0, 0, 2, 1, c_START + 4,    c_W1, 0);
        vt[15] = mk(0, 0, 0,    0, 0, 0, 0,       0, c_START + 8,     0, 0, 2, 1, c_START + 8,    c_W2, 0);
        vt[16] = mk(0, 0, 0,    0, 1, 1, c_START, 0, c_START + 12,    0, 0, 2, 0, 0,              0,    0);
        vt[17] = mk(0, 0, 0,    0, 0, 0, 0,       0, c_START,         0, 0, 2, 1, c_START,        c_W0, 0);
        vt[18] = mk(0, 0, 0,    0, 0, 0, 0,       1, c_START + 4,     0, 0, 3, 0, 0,              0,    0);
        vt[19] = mk(1, 0, 0,    0, 0, 0, 0,       0, c_START + 4,     0, 0, 3, 0, 0,              0,    0);
        vt[20] = mk(0, 0, 0,    1, 0, 0, 0,       0, c_START + 4,     0, 0, 2, 0, 0,              0,    0);
        vt[21] = mk(0, 0, 0,    0, 0, 0, 0,       0, c_START + 4,     0, 0, 2, 1, c_START + 4,    c_W1, 0);
        vt[22] = mk(0, 0, 0,    0, 0, 1, c_START + 2, 0, c_START + 8, 0, 0, 4, 0, 0,              0,    1);
        vt[23] = mk(0, 0, 0,    1, 0, 0, 0,       0, c_START + 8,     0, 0, 4, 0, 0,              0,    1);

        // Reset state
        do_reset();
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_imem_pc", imem_pc, c_START);
        chk("rst_if_valid", 32'(if_valid), 32'd0);
        chk("rst_fault", 32'(fault), 32'd0);
        chk("rst_load_ready", 32'(load_ready), 32'd0);

        // Load, fetch, stall, redirect-vs-stall, halt/resume, misaligned redirect
        for (int i = 0; i < 24; i++) begin
            load_en = vt[i].le; load_valid = vt[i].lv; load_data = vt[i].ld;
            start = vt[i].st; stall = vt[i].sl; redirect_valid = vt[i].rv;
            redirect_pc = vt[i].rpc; halt = vt[i].ht;
            #1;
            chk($sformatf("v%0d_imem_pc", i), imem_pc, vt[i].e_ipc);
            chk($sformatf("v%0d_imem_we", i), 32'(imem_we), 32'(vt[i].e_we));
            chk($sformatf("v%0d_load_ready", i), 32'(load_ready), 32'(vt[i].e_lr));
            if (vt[i].e_we) chk($sformatf("v%0d_wdata", i), imem_wdata, vt[i].ld);
            step();
            chk($sformatf("v%0d_state", i), 32'(state), 32'(vt[i].e_st));
            chk($sformatf("v%0d_if_valid", i), 32'(if_valid), 32'(vt[i].e_ifv));
            chk($sformatf("v%0d_fault", i), 32'(fault), 32'(vt[i].e_flt));
            if (vt[i].e_ifv) begin
                chk($sformatf("v%0d_if_pc", i), if_pc, vt[i].e_ifpc);
                chk($sformatf("v%0d_if_instr", i), if_instruction, vt[i].e_ins);
            end
        end
        idle_inputs();
        chk("misalign_fault_pc", fault_pc, c_START + 2);

        // End of range: last word fetched, then fault at one past the end
        do_reset();
        start = 1; step(); start = 0;
        redirect_valid = 1; redirect_pc = c_START + 32'h0F8; step(); redirect_valid = 0;
        chk("eor_bubble", 32'(if_valid), 32'd0);
        step();
        chk("eor_pc_f8", if_pc, c_START + 32'h0F8);
        chk("eor_ins_f8", if_instruction, 32'hA000_003E);
        step();
        chk("eor_pc_fc", if_pc, c_START + 32'h0FC);
        chk("eor_ins_fc", if_instruction, 32'hA000_003F);
        chk("eor_valid_fc", 32'(if_valid), 32'd1);
        step();
        chk("eor_state", 32'(state), 32'd4);
        chk("eor_fault_pc", fault_pc, c_START + 32'h100);
        chk("eor_if_valid", 32'(if_valid), 32'd0);

        // Out-of-range redirects, above and below the window
        redirect_fault(c_START + 32'h100);
        redirect_fault(c_START - 32'd4);

        // Reset mid-LOAD after 10 words
        do_reset();
        load_en = 1; step();
        load_valid = 1;
        for (int i = 0; i < 10; i++) begin
            load_data = 32'hB000_0000 + 32'(i);
            step();
        end
        load_valid = 0; rst = 1; step(); rst = 0;
        chk("midload_rst_state", 32'(state), 32'd0);
        chk("midload_rst_lr", 32'(load_ready), 32'd0);
        step();
        chk("reload_state", 32'(state), 32'd1);
        chk("reload_imem_pc", imem_pc, c_START);
        chk("reload_lr", 32'(load_ready), 32'd1);

        // Full-depth load exits on its own after the last word
        load_valid = 1;
        for (int i = 0; i < 64; i++) begin
            load_data = 32'hC000_0000 + 32'(i);
            step();
            if (i == 62) chk("full_load_62_state", 32'(state), 32'd1);
        end
        load_valid = 0;
        chk("full_load_state", 32'(state), 32'd0);
        chk("full_load_lr", 32'(load_ready), 32'd0);
        chk("full_load_pc", imem_pc, c_START);
        load_en = 0; start = 1; step(); start = 0;
        step();
        chk("full_load_ins0", if_instruction, 32'hC000_0000);
        step();
        chk("full_load_ins1", if_instruction, 32'hC000_0001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, got running expected finished");
        $fatal(1);
    end

endmodule
`default_nettype wire
